pattern_stream_sequencer: RTL and testbench
===========================================

// Module: pattern_stream_sequencer
// PURPOSE
//  Sequences readout of the pattern FIFO (256b-in / 32b-out) toward the sensor MSTREAM ODDR bank.
//  Per subframe: waits for a full pattern in the FIFO, asserts stream_en for cfg_rows cycles,
//  then holds an exposure gap; repeats for cfg_num_sub subframes, then reports frame done.
//  Runs in the stream clock domain; drives the FIFO rd_en / sensor stream enable.
// PARAMETERS
//  ROW_W   12  width of row count and FIFO read-count input (max 4095 rows)
//  SUB_W   16  width of subframe count
//  EXP_W   24  width of exposure-gap cycle count
// PORTS
//  clk             in   1      stream clock; all logic on posedge
//  reset           in   1      synchronous, active-high
//  start           in   1      pulse: latch cfg_* and begin frame (ignored while busy)
//  abort           in   1      pulse: terminate frame, return to IDLE
//  cfg_rows        in   ROW_W  32b words (rows) per pattern
//  cfg_num_sub     in   SUB_W  subframes per frame
//  cfg_exp_cycles  in   EXP_W  idle cycles after each pattern burst
//  fifo_rd_count   in   ROW_W  read-side data count of pattern FIFO
//  stream_en       out  1      FIFO rd_en / sensor stream enable (registered)
//  sub_start       out  1      1-cycle pulse on first stream_en cycle of each subframe
//  sub_idx         out  SUB_W  current subframe index, 0-based
//  busy            out  1      high in every state except IDLE
//  stalled         out  1      high while in CHECK waiting for data
//  frame_done      out  1      1-cycle pulse at normal frame completion
//  aborted         out  1      1-cycle pulse when abort terminates an active frame
//  stall_cycles    out  32     total CHECK-wait cycles this frame (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; latched config 0. Reset mid-frame drops stream_en next edge.
//  States: IDLE -> CHECK -> STREAM -> EXPOSE -> (CHECK | DONE) -> IDLE.
//  IDLE: start=1 latches cfg_* and clears sub_idx/stall_cycles; next state CHECK.
//    cfg_rows==0 or cfg_num_sub==0 -> go DONE directly (no stream_en ever asserted).
//  CHECK: stalled=1. If fifo_rd_count >= rows_q -> STREAM; stream_en=1 and sub_start=1 on the
//    following cycle. Otherwise remain (no timeout).
//  STREAM: stream_en high for exactly rows_q consecutive cycles, no gaps; row counter reloads
//    rows_q on entry and decrements per cycle; deasserts on the edge the count reaches 0.
//  EXPOSE: stream_en=0 for exactly exp_q cycles (exp_q==0 -> zero cycles, straight to next).
//    On exit: if sub_idx==num_sub_q-1 -> DONE, else sub_idx+=1 and -> CHECK.
//  DONE: frame_done=1 for one cycle, busy=0 next cycle, -> IDLE. sub_idx holds last value.
//  abort: any non-IDLE state -> IDLE on the next edge; stream_en 0 that edge; aborted=1 one cycle;
//    frame_done not pulsed. abort in IDLE ignored. abort and start same cycle: abort wins.
//  start while busy: ignored; cfg_* changes while busy: no effect until next start.
//  Latency start->first stream_en: 2 cycles minimum (IDLE->CHECK, CHECK->STREAM).
//  Comparison is unsigned; rd_count is conservative (lags) so never under-runs the FIFO.
// CONFIGURATION
//  SEQ_STALL_CNT_EN defined: stall_cycles increments each CHECK cycle where data is insufficient,
//    saturates at 32'hFFFF_FFFF, clears on accepted start and on reset.
//  SEQ_STALL_CNT_EN undefined: stall_cycles tied to 32'd0; no counter logic synthesised.
// STRUCTURE
//  Package pat_seq_pkg: state enum (S_IDLE,S_CHECK,S_STREAM,S_EXPOSE,S_DONE), default widths.
//  Sub-module seq_down_counter (load/dec/zero flag, parameterised width): one instance for rows,
//    one for exposure gap. Everything else in the top FSM.
// TESTING
//  rows=4, num_sub=3, exp=5, rd_count=4095 -> 3 bursts of 4 stream_en cycles, 5-cycle gaps,
//    sub_start x3, frame_done once; start->first stream_en = 2 cycles.
//  rows=8, rd_count=7 for 10 cycles then 8 -> stalled high 10+ cycles, no stream_en until count=8;
//    with SEQ_STALL_CNT_EN stall_cycles=10, without =0.
//  abort during 3rd STREAM cycle (rows=8) -> stream_en low next edge, aborted pulse, no frame_done,
//    busy=0; next start runs a full clean frame.
//  cfg_num_sub=0 or cfg_rows=0 -> frame_done pulse, zero stream_en cycles.
//  exp=0, rows=1, num_sub=4 -> stream_en pattern 1,0(CHECK),1,... exactly 4 high cycles total.
//  start pulsed mid-frame with new cfg -> ignored; reset asserted in EXPOSE -> all outputs 0.

Source files
------------

// File: rtl/pat_seq_pkg.sv
// Shared state encoding and default widths for the pattern stream sequencer.
package pat_seq_pkg;

  localparam int unsigned ROW_W_DEF = 12;
  localparam int unsigned SUB_W_DEF = 16;
  localparam int unsigned EXP_W_DEF = 24;

  // Sequencer states, kept as plain constants so older tools can consume them.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CHECK  = 3'd1;
  localparam state_t S_STREAM = 3'd2;
  localparam state_t S_EXPOSE = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter used for the row burst and the exposure gap.
// zero: count is 0; last: count is 1, i.e. the next decrement reaches zero.
module seq_down_counter #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count_q;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/pattern_stream_sequencer.sv
// Pattern FIFO readout sequencer for the sensor MSTREAM path.
// Per subframe: wait for a full pattern, stream cfg_rows words, hold an exposure gap.
// Optional feature macro: SEQ_STALL_CNT_EN enables the saturating stall-cycle counter;
// without it stall_cycles is tied to zero.
module pattern_stream_sequencer
  import pat_seq_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF,
  parameter int unsigned SUB_W = SUB_W_DEF,
  parameter int unsigned EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [SUB_W-1:0] cfg_num_sub,
  input  logic [EXP_W-1:0] cfg_exp_cycles,
  input  logic [ROW_W-1:0] fifo_rd_count,
  output logic             stream_en,
  output logic             sub_start,
  output logic [SUB_W-1:0] sub_idx,
  output logic             busy,
  output logic             stalled,
  output logic             frame_done,
  output logic             aborted,
  output logic [31:0]      stall_cycles
);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] rows_q;
  logic [SUB_W-1:0] num_sub_q;
  logic [EXP_W-1:0] exp_q;
  logic [SUB_W-1:0] sub_idx_q;
  logic             stream_en_q, sub_start_q, aborted_q;

  logic latch, row_load, exp_load, sub_inc;
  logic data_ok, last_sub, abort_hit;
  logic row_zero, row_last, exp_zero, exp_last;
  logic row_end, exp_end;

  assign abort_hit = abort && (state_q != S_IDLE);
  // rd_count lags the true fill level, so this compare never under-runs the FIFO.
  assign data_ok   = (fifo_rd_count >= rows_q);
  assign last_sub  = (sub_idx_q == (num_sub_q - SUB_W'(1)));
  // The zero terms only guard against a counter that was never loaded.
  assign row_end   = row_last || row_zero;
  assign exp_end   = exp_last || exp_zero;

  seq_down_counter #(
    .WIDTH (ROW_W)
  ) u_row_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (row_load),
    .load_val (rows_q),
    .dec      (state_q == S_STREAM),
    .zero     (row_zero),
    .last     (row_last)
  );

  seq_down_counter #(
    .WIDTH (EXP_W)
  ) u_exp_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (exp_load),
    .load_val (exp_q),
    .dec      (state_q == S_EXPOSE),
    .zero     (exp_zero),
    .last     (exp_last)
  );

  // Next-state decode; abort from any active state overrides the normal flow.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    row_load = 1'b0;
    exp_load = 1'b0;
    sub_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          latch = 1'b1;
          if ((cfg_rows == '0) || (cfg_num_sub == '0)) state_d = S_DONE;
          else                                          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (data_ok) begin
          state_d  = S_STREAM;
          row_load = 1'b1;
        end
      end
      S_STREAM: begin
        if (row_end) begin
          if (exp_q != '0) begin
            state_d  = S_EXPOSE;
            exp_load = 1'b1;
          end else if (last_sub) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CHECK;
            sub_inc = 1'b1;
          end
        end
      end
      S_EXPOSE: begin
        if (exp_end) begin
          if (last_sub) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CHECK;
            sub_inc = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      sub_inc = 1'b0;
    end
  end

  // State, latched configuration and subframe index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      num_sub_q <= '0;
      exp_q     <= '0;
      sub_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        rows_q    <= cfg_rows;
        num_sub_q <= cfg_num_sub;
        exp_q     <= cfg_exp_cycles;
        sub_idx_q <= '0;
      end else if (sub_inc) begin
        sub_idx_q <= sub_idx_q + SUB_W'(1);
      end
    end
  end

  // Registered stream enable and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      stream_en_q <= 1'b0;
      sub_start_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      stream_en_q <= (state_d == S_STREAM);
      sub_start_q <= (state_q == S_CHECK) && (state_d == S_STREAM);
      aborted_q   <= abort_hit;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count CHECK cycles that found too little data; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (latch) begin
      stall_q <= '0;
    end else if ((state_q == S_CHECK) && !data_ok && !abort && (stall_q != STALL_MAX)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

  assign stream_en  = stream_en_q;
  assign sub_start  = sub_start_q;
  assign sub_idx    = sub_idx_q;
  assign busy       = (state_q != S_IDLE);
  assign stalled    = (state_q == S_CHECK);
  assign frame_done = (state_q == S_DONE);
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_pattern_stream_sequencer.sv
// Self-checking bench for pattern_stream_sequencer: a frame-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_pattern_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [11:0] cfg_rows, fifo_rd_count;
  logic [15:0] cfg_num_sub;
  logic [23:0] cfg_exp_cycles;
  logic        stream_en, sub_start, busy, stalled, frame_done, aborted;
  logic [15:0] sub_idx;
  logic [31:0] stall_cycles;

`ifdef SEQ_STALL_CNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  pattern_stream_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_rows       (cfg_rows),
    .cfg_num_sub    (cfg_num_sub),
    .cfg_exp_cycles (cfg_exp_cycles),
    .fifo_rd_count  (fifo_rd_count),
    .stream_en      (stream_en),
    .sub_start      (sub_start),
    .sub_idx        (sub_idx),
    .busy           (busy),
    .stalled        (stalled),
    .frame_done     (frame_done),
    .aborted        (aborted),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit cmp_en  = 1'b0;

  always @(posedge clk) cyc++;

  // Expected outputs for the cycle following each rising edge.
  logic        e_stream, e_sub_start, e_busy, e_stalled, e_done, e_aborted;
  logic [15:0] e_sub_idx;
  logic [31:0] e_stall;

  task automatic m_clear();
    e_stream = 0; e_sub_start = 0; e_busy = 0; e_stalled = 0;
    e_done = 0; e_aborted = 0; e_sub_idx = '0; e_stall = '0;
  endtask

  // Advance one edge; report whether reset or abort ended the frame there.
  task automatic m_edge(output bit killed);
    @(posedge clk);
    e_aborted = 0; e_sub_start = 0; e_done = 0;
    killed = 0;
    if (reset) begin
      m_clear();
      killed = 1;
    end else if (abort) begin
      e_aborted = 1; e_busy = 0; e_stalled = 0; e_stream = 0;
      killed = 1;
    end
  endtask

  // A whole frame as the sequence of phases it must go through.
  task automatic m_frame(input int rows, input int nsub, input int ex);
    bit k, ok;
    if (rows != 0 && nsub != 0) begin
      for (int s = 0; s < nsub; s++) begin
        e_sub_idx = 16'(s);
        ok = 0;
        while (!ok) begin
          e_busy = 1; e_stalled = 1; e_stream = 0;
          m_edge(k);
          if (k) return;
          ok = (int'(fifo_rd_count) >= rows);
          if (!ok && StallEn && e_stall != 32'hFFFF_FFFF) e_stall++;
        end
        for (int r = 0; r < rows; r++) begin
          e_stalled = 0; e_stream = 1; e_sub_start = (r == 0);
          m_edge(k);
          if (k) return;
        end
        for (int g = 0; g < ex; g++) begin
          e_stream = 0;
          m_edge(k);
          if (k) return;
        end
      end
    end
    e_stream = 0; e_stalled = 0; e_busy = 1; e_done = 1;
    m_edge(k);
  endtask

  initial begin : model
    m_clear();
    forever begin
      e_busy = 0; e_stalled = 0; e_stream = 0; e_done = 0;
      @(posedge clk);
      e_aborted = 0; e_sub_start = 0;
      if (reset) begin
        m_clear();
      end else if (start && !abort) begin
        e_sub_idx = '0;
        e_stall   = '0;
        m_frame(int'(cfg_rows), int'(cfg_num_sub), int'(cfg_exp_cycles));
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_tests++;
      if ({stream_en, sub_start, busy, stalled, frame_done, aborted, sub_idx, stall_cycles} !==
          {e_stream, e_sub_start, e_busy, e_stalled, e_done, e_aborted, e_sub_idx, e_stall}) begin
        n_fail++;
        $display("FAIL model_cmp @%0t: got en=%b ss=%b bz=%b st=%b dn=%b ab=%b idx=%0d stall=%0d, %s",
                 $time, stream_en, sub_start, busy, stalled, frame_done, aborted, sub_idx,
                 stall_cycles, $sformatf("expected en=%b ss=%b bz=%b st=%b dn=%b ab=%b idx=%0d stall=%0d",
                 e_stream, e_sub_start, e_busy, e_stalled, e_done, e_aborted, e_sub_idx, e_stall));
      end
    end
  end

  // Event counters for the hand-computed checks.
  int c_stream, c_sub, c_done, c_abort, c_stalled;
  always @(negedge clk) begin
    if (stream_en)  c_stream++;
    if (sub_start)  c_sub++;
    if (frame_done) c_done++;
    if (aborted)    c_abort++;
    if (stalled)    c_stalled++;
  end

  task automatic clr_counts();
    c_stream = 0; c_sub = 0; c_done = 0; c_abort = 0; c_stalled = 0;
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (frame_done !== 1'b1 && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (frame_done !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL %s: frame_done timeout, got 0, expected 1", name);
    end
    @(negedge clk);
  endtask

  task automatic wait_stream(input logic val, input string name);
    int i = 0;
    while (stream_en !== val && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (stream_en !== val) begin
      n_tests++; n_fail++;
      $display("FAIL %s: stream_en timeout, got %b, expected %b", name, stream_en, val);
    end
  endtask

  task automatic kick(input int rows, input int nsub, input int ex);
    cfg_rows = 12'(rows); cfg_num_sub = 16'(nsub); cfg_exp_cycles = 24'(ex);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin : stim
    int t0;
    reset = 1; start = 0; abort = 0;
    cfg_rows = '0; cfg_num_sub = '0; cfg_exp_cycles = '0; fifo_rd_count = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    cmp_en = 1;
    chk("reset_outputs", longint'({stream_en, sub_start, busy, stalled, frame_done, aborted,
        sub_idx, stall_cycles}), 0);

    // Basic frame: 3 bursts of 4 rows, 5-cycle gaps, plenty of data.
    fifo_rd_count = 12'd4095;
    @(negedge clk);
    clr_counts();
    t0 = cyc;
    kick(4, 3, 5);
    wait_stream(1'b1, "basic_first");
    chk("start_latency", cyc - t0, 2);
    wait_done("basic");
    chk("basic_stream_cycles", c_stream, 12);
    chk("basic_sub_starts", c_sub, 3);
    chk("basic_frame_done", c_done, 1);
    chk("basic_last_sub_idx", sub_idx, 2);
    chk("basic_idle_busy", busy, 0);

    // Data starvation: 10 insufficient CHECK cycles before the pattern lands.
    clr_counts();
    fifo_rd_count = 12'd7;
    kick(8, 1, 0);
    repeat (10) @(negedge clk);
    chk("stall_no_stream", c_stream, 0);
    fifo_rd_count = 12'd8;
    wait_done("stall");
    chk("stall_cycles", stall_cycles, StallEn ? 10 : 0);
    chk("stall_stalled_cycles", c_stalled, 11);
    chk("stall_stream_cycles", c_stream, 8);

    // Abort during the third STREAM cycle, then a clean frame.
    fifo_rd_count = 12'd4095;
    clr_counts();
    kick(8, 2, 3);
    wait_stream(1'b1, "abort_first");
    @(negedge clk);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_stream_low", stream_en, 0);
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", c_done, 0);
    chk("abort_pulse_count", c_abort, 1);
    clr_counts();
    kick(8, 2, 3);
    wait_done("after_abort");
    chk("after_abort_stream", c_stream, 16);
    chk("after_abort_done", c_done, 1);

    // Degenerate configurations: done pulse, no streaming.
    clr_counts();
    kick(0, 3, 2);
    wait_done("rows0");
    kick(5, 0, 2);
    wait_done("nsub0");
    chk("degenerate_stream", c_stream, 0);
    chk("degenerate_done", c_done, 2);

    // No exposure gap, single-row bursts.
    clr_counts();
    kick(1, 4, 0);
    wait_done("exp0");
    chk("exp0_stream", c_stream, 4);
    chk("exp0_check_cycles", c_stalled, 4);

    // Start with new config mid-frame is ignored.
    clr_counts();
    kick(3, 2, 2);
    repeat (2) @(negedge clk);
    kick(9, 5, 1);
    wait_done("midstart");
    chk("midstart_stream", c_stream, 6);

    // Reset while in EXPOSE.
    kick(2, 2, 10);
    wait_stream(1'b1, "rst_stream");
    wait_stream(1'b0, "rst_expose");
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("reset_in_expose", longint'({stream_en, sub_start, busy, stalled, frame_done, aborted,
        sub_idx, stall_cycles}), 0);

    // Randomized traffic checked by the model every cycle.
    for (int it = 0; it < 40; it++) begin
      cfg_rows = 12'($urandom_range(0, 6));
      cfg_num_sub = 16'($urandom_range(0, 3));
      cfg_exp_cycles = 24'($urandom_range(0, 4));
      start = 1;
      for (int c = 0; c < int'($urandom_range(30, 80)); c++) begin
        @(negedge clk);
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 39) == 0);
        reset = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 3) == 0) fifo_rd_count = 12'($urandom_range(0, 8));
        if (start) begin
          cfg_rows = 12'($urandom_range(0, 6));
          cfg_num_sub = 16'($urandom_range(0, 3));
          cfg_exp_cycles = 24'($urandom_range(0, 4));
        end
      end
      @(negedge clk);
      start = 0; abort = 0; reset = 0;
    end
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
